ram_timing_ctrl: RTL and testbench
==================================

Name: ram_timing_ctrl

Overview:
Behavioural main-memory model with a wait-state controller. It sits directly downstream of the bus/coherence memory controller and consumes its RAM-side request (ramREN, ramWEN, ramaddr, ramstore). It holds a word-addressed storage array, inserts a parameterised access latency, and returns ramload and ramstate (FREE/BUSY/ACCESS/ERROR). The upstream controller advances its write-back, load and icache states on ramstate == ACCESS.

Parameters:
ADDR_W, 14, word-address width; the array holds 2^ADDR_W 32-bit words.
LAT, 2, number of BUSY cycles before ACCESS (0 is legal).

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  reset
ramREN  input  1  read request, held until ACCESS is seen
ramWEN  input  1  write request, held until ACCESS is seen
ramaddr  input  32  byte address; word index = ramaddr[ADDR_W+1:2]; bits [1:0] and bits above ADDR_W+1 ignored (aliasing)
ramstore  input  32  write data
ramload  output  32  read data, valid only while ramstate == ACCESS
ramstate  output  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3 (ramstate_t encoding)

Interface (already decided): one clock, CLK; reset RST is asynchronous and active-high.

Behaviour:
- States:
  - IDLE: ramstate = FREE
  - WAIT: ramstate = BUSY
  - ACC: ramstate = ACCESS
  - ERR: ramstate = ERROR
- ramstate is decoded combinationally from the state register.
- Registers: state, cnt (wide enough for LAT), latched word address la, latched op lw (1 = write), latched data ld, ramload register.
- Reset (async, RST=1):
  - state = IDLE, cnt = 0, la/lw/ld = 0, ramload = 0.
  - ramstate reads FREE immediately.
  - The array is not cleared.
  - Any in-flight write is dropped; no commit.
- IDLE transitions:
  - ramREN & ramWEN: go to ERR.
  - Exactly one request: capture la, lw, ld. If LAT == 0, go to ACC; otherwise go to WAIT with cnt = LAT-1.
  - No request: stay in IDLE.
- WAIT transitions, in priority order:
  1. Both requests: go to ERR.
  2. No request: go to IDLE (abort, no commit).
  3. Word address or op differs from the latched value: recapture and restart with cnt = LAT-1, stay in WAIT.
  4. ramstore changed on a write: recapture ld only; no restart.
  5. cnt == 0: go to ACC.
  6. Otherwise: cnt decrements.
- On the WAIT-to-ACC edge (or IDLE-to-ACC when LAT = 0):
  - Read: ramload <= mem[la].
  - Write: ramload <= 0.
- ACC:
  - Lasts exactly one cycle.
  - A write commits mem[la] <= ld on the edge that leaves ACC.
  - Always returns to IDLE. This one FREE turnaround cycle lets the upstream controller change address before the next beat.
  - ramload is cleared to 0 on leaving ACC.
- ERR:
  - Held while ramREN & ramWEN; no array access.
  - Goes to IDLE when the two are no longer both asserted.
- Latency: request first visible in cycle 0 gives BUSY in cycles 1..LAT and ACCESS in cycle LAT+1. A two-beat transfer therefore takes 2*(LAT+2) cycles.
- Read-after-write to the same word returns the new data, because the commit precedes the next IDLE sample.
- Requests held unchanged after ACCESS are treated as a new access (re-executed).

Test Plan:
1. LAT=2, write addr 0x40 data 0xDEADBEEF held until ACCESS → ramstate FREE,BUSY,BUSY,ACCESS in cycles 0–3 and FREE in cycle 4; then read 0x40 → ACCESS in read cycle 3 with ramload=0xDEADBEEF, and ramload=0 in all other cycles.
2. Back-to-back two-beat write-back: 0x80←0x11111111, then 0x84←0x22222222 (address switched in the FREE turnaround cycle) → two ACCESS pulses 4 cycles apart; readback gives both values; read of 0x87 returns 0x22222222 (offset ignored).
3. Read 0x40 from cycle 0, address switched to 0x44 in cycle 2 → BUSY in cycles 1–4, ACCESS in cycle 5 with ramload=mem[0x44]; no ACCESS for 0x40.
4. ramREN=ramWEN=1 for 3 cycles on addr 0x40 holding 0xDEADBEEF, data 0x0 → ERROR in cycles 1–3, FREE once cleared; subsequent read of 0x40 still returns 0xDEADBEEF.
5. Write 0x100←0xCAFEF00D, RST pulsed in cycle 2 (mid-WAIT) → ramstate FREE asynchronously; read of 0x100 returns its prior value, no commit.
6. LAT=0 build: read request in cycle 0 → ACCESS in cycle 1, FREE in cycle 2; request dropped in cycle 1 of WAIT (LAT=2 build) → IDLE, no ACCESS.

Source files
------------

// File: rtl/ram_timing_ctrl.sv
// ram_timing_ctrl
// ----------------
// Behavioural main-memory model with a wait-state controller. It accepts the
// RAM-side request of the upstream memory controller, holds a word-addressed
// array of 2^ADDR_W 32-bit words, inserts LAT busy cycles before each access,
// and reports progress through ramstate (FREE/BUSY/ACCESS/ERROR).
//
// Parameters:
//   ADDR_W   word-address width (array depth is 2^ADDR_W words), at most 30
//   LAT      number of BUSY cycles before ACCESS (0 is legal)
//
// Ports:
//   CLK       in   1   clock, all state updates on the rising edge
//   RST       in   1   asynchronous active-high reset
//   ramREN    in   1   read request, held until ACCESS is seen
//   ramWEN    in   1   write request, held until ACCESS is seen
//   ramaddr   in   32  byte address, word index = ramaddr[ADDR_W+1:2]
//   ramstore  in   32  write data
//   ramload   out  32  read data, valid only while ramstate == ACCESS
//   ramstate  out  2   FREE=0, BUSY=1, ACCESS=2, ERROR=3

module ram_timing_ctrl #(
    parameter int ADDR_W = 14,
    parameter int LAT    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ramREN,
    input  logic        ramWEN,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);

    // The counter only ever holds values 0..LAT-1.
    localparam int CNT_W = (LAT > 2) ? $clog2(LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'((LAT > 0) ? LAT - 1 : 0);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACC  = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [ADDR_W-1:0]  la, la_n;
    logic               lw, lw_n;
    logic [31:0]        ld, ld_n;
    logic [31:0]        load_n;

    logic [31:0]        mem [DEPTH];

    logic [ADDR_W-1:0]  req_addr;
    logic               both_req;
    logic               any_req;

    // Byte offset and address bits above the array alias away.
    logic               unused_addr_bits;

    assign req_addr         = ramaddr[ADDR_W+1:2];
    assign both_req         = ramREN & ramWEN;
    assign any_req          = ramREN | ramWEN;
    assign unused_addr_bits = ^{ramaddr[31:ADDR_W+2], ramaddr[1:0]};

    // State and latched-request registers. Reset drops any pending request,
    // so an in-flight write never reaches the array.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            la      <= '0;
            lw      <= 1'b0;
            ld      <= '0;
            ramload <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            la      <= la_n;
            lw      <= lw_n;
            ld      <= ld_n;
            ramload <= load_n;
        end
    end

    // The array is never cleared. A write commits on the edge that leaves
    // ACC, so a read sampled in the following IDLE cycle sees the new data.
    always_ff @(posedge CLK) begin
        if (state == ACC && lw) begin
            mem[la] <= ld;
        end
    end

    // Next-state logic. In WAIT the checks are ordered: conflicting requests,
    // abort, address/op change (restart the wait), write-data change (update
    // data only), then the countdown itself.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        la_n    = la;
        lw_n    = lw;
        ld_n    = ld;
        load_n  = ramload;

        case (state)
            IDLE: begin
                if (both_req) begin
                    state_n = ERR;
                end else if (any_req) begin
                    la_n = req_addr;
                    lw_n = ramWEN;
                    ld_n = ramstore;
                    if (LAT == 0) begin
                        state_n = ACC;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = CNT_RELOAD;
                    end
                end
            end

            WAIT: begin
                if (both_req) begin
                    state_n = ERR;
                end else if (!any_req) begin
                    state_n = IDLE;
                end else if (req_addr != la || ramWEN != lw) begin
                    la_n  = req_addr;
                    lw_n  = ramWEN;
                    ld_n  = ramstore;
                    cnt_n = CNT_RELOAD;
                end else if (lw && ramstore != ld) begin
                    ld_n = ramstore;
                end else if (cnt == '0) begin
                    state_n = ACC;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end

            ACC: begin
                state_n = IDLE;
                load_n  = '0;
            end

            ERR: begin
                if (!both_req) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        // Read data is fetched on the edge that enters ACC. The address is
        // taken from the next-state latch so the zero-latency path, which
        // captures and accesses on the same edge, reads the right word.
        if (state_n == ACC && state != ACC) begin
            load_n = lw_n ? 32'd0 : mem[la_n];
        end
    end

    // External status encoding.
    always_comb begin
        ramstate = 2'd0;
        case (state)
            IDLE:    ramstate = 2'd0;
            WAIT:    ramstate = 2'd1;
            ACC:     ramstate = 2'd2;
            ERR:     ramstate = 2'd3;
            default: ramstate = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_ram_timing_ctrl.sv
// tb_ram_timing_ctrl
// -------------------
// Directed bench for ram_timing_ctrl. One instance uses the default LAT=2,
// a second instance uses LAT=0. Both share clock and reset.

module tb_ram_timing_ctrl;

    localparam logic [31:0] FREE   = 32'd0;
    localparam logic [31:0] BUSY   = 32'd1;
    localparam logic [31:0] ACCESS = 32'd2;
    localparam logic [31:0] ERROR  = 32'd3;

    logic        clk;
    logic        rst;

    logic        ren, wen;
    logic [31:0] addr, wdata, load;
    logic [1:0]  state;

    logic        ren0, wen0;
    logic [31:0] addr0, wdata0, load0;
    logic [1:0]  state0;

    int pass_count  = 0;
    int fail_count  = 0;
    int total_count = 0;

    ram_timing_ctrl #(.ADDR_W(14), .LAT(2)) dut (
        .CLK      (clk),
        .RST      (rst),
        .ramREN   (ren),
        .ramWEN   (wen),
        .ramaddr  (addr),
        .ramstore (wdata),
        .ramload  (load),
        .ramstate (state)
    );

    ram_timing_ctrl #(.ADDR_W(14), .LAT(0)) dut0 (
        .CLK      (clk),
        .RST      (rst),
        .ramREN   (ren0),
        .ramWEN   (wen0),
        .ramaddr  (addr0),
        .ramstore (wdata0),
        .ramload  (load0),
        .ramstate (state0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_count++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        ren   = r;
        wen   = w;
        addr  = a;
        wdata = d;
    endtask

    task automatic drive0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        ren0   = r;
        wen0   = w;
        addr0  = a;
        wdata0 = d;
    endtask

    // One LAT=2 access starting from an IDLE cycle: FREE, BUSY, BUSY, ACCESS.
    // Leaves the request applied in the ACCESS cycle.
    task automatic beat(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_load);
        drive(!w, w, a, d);
        check({tag, " c0 state"}, {30'd0, state}, FREE);
        check({tag, " c0 load"}, load, 32'd0);
        tick();
        check({tag, " c1 state"}, {30'd0, state}, BUSY);
        check({tag, " c1 load"}, load, 32'd0);
        tick();
        check({tag, " c2 state"}, {30'd0, state}, BUSY);
        tick();
        check({tag, " c3 state"}, {30'd0, state}, ACCESS);
        check({tag, " c3 load"}, load, exp_load);
    endtask

    // Drop the request and confirm the FREE turnaround with cleared data.
    task automatic finish_idle(input string tag);
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        check({tag, " idle state"}, {30'd0, state}, FREE);
        check({tag, " idle load"}, load, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        drive0(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        tick();

        // Reset state of both instances.
        check("reset state", {30'd0, state}, FREE);
        check("reset load", load, 32'd0);
        check("reset state lat0", {30'd0, state0}, FREE);
        check("reset load lat0", load0, 32'd0);
        rst = 1'b0;
        tick();

        // Single write then readback.
        beat("t1 wr40", 1'b1, 32'h40, 32'hDEADBEEF, 32'd0);
        finish_idle("t1 wr40");
        beat("t1 rd40", 1'b0, 32'h40, 32'd0, 32'hDEADBEEF);
        finish_idle("t1 rd40");

        // Back-to-back write-back, address switched in the turnaround cycle.
        beat("t2 wr80", 1'b1, 32'h80, 32'h11111111, 32'd0);
        drive(1'b0, 1'b1, 32'h84, 32'h22222222);
        tick();
        check("t2 turnaround state", {30'd0, state}, FREE);
        check("t2 turnaround load", load, 32'd0);
        beat("t2 wr84", 1'b1, 32'h84, 32'h22222222, 32'd0);
        finish_idle("t2 wr84");
        beat("t2 rd80", 1'b0, 32'h80, 32'd0, 32'h11111111);
        finish_idle("t2 rd80");
        beat("t2 rd84", 1'b0, 32'h84, 32'd0, 32'h22222222);
        finish_idle("t2 rd84");
        beat("t2 rd87", 1'b0, 32'h87, 32'd0, 32'h22222222);
        finish_idle("t2 rd87");
        beat("t2 rd alias hi", 1'b0, 32'h00010084, 32'd0, 32'h22222222);
        finish_idle("t2 rd alias hi");

        // Address change mid-wait restarts the countdown.
        beat("t3 wr44", 1'b1, 32'h44, 32'h44444444, 32'd0);
        finish_idle("t3 wr44");
        drive(1'b1, 1'b0, 32'h40, 32'd0);
        check("t3 c0 state", {30'd0, state}, FREE);
        tick();
        check("t3 c1 state", {30'd0, state}, BUSY);
        tick();
        check("t3 c2 state", {30'd0, state}, BUSY);
        drive(1'b1, 1'b0, 32'h44, 32'd0);
        tick();
        check("t3 c3 state", {30'd0, state}, BUSY);
        check("t3 c3 load", load, 32'd0);
        tick();
        check("t3 c4 state", {30'd0, state}, BUSY);
        tick();
        check("t3 c5 state", {30'd0, state}, ACCESS);
        check("t3 c5 load", load, 32'h44444444);
        finish_idle("t3");

        // Conflicting requests.
        drive(1'b1, 1'b1, 32'h40, 32'd0);
        tick();
        check("t4 c1 state", {30'd0, state}, ERROR);
        tick();
        check("t4 c2 state", {30'd0, state}, ERROR);
        tick();
        check("t4 c3 state", {30'd0, state}, ERROR);
        check("t4 c3 load", load, 32'd0);
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        check("t4 c4 state", {30'd0, state}, FREE);
        beat("t4 rd40", 1'b0, 32'h40, 32'd0, 32'hDEADBEEF);
        finish_idle("t4 rd40");

        // Reset in the middle of a write drops the write.
        beat("t5 wr100", 1'b1, 32'h100, 32'h12345678, 32'd0);
        finish_idle("t5 wr100");
        drive(1'b0, 1'b1, 32'h100, 32'hCAFEF00D);
        tick();
        check("t5 c1 state", {30'd0, state}, BUSY);
        tick();
        check("t5 c2 state", {30'd0, state}, BUSY);
        rst = 1'b1;
        #1;
        check("t5 async reset state", {30'd0, state}, FREE);
        check("t5 async reset load", load, 32'd0);
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        rst = 1'b0;
        tick();
        check("t5 after reset state", {30'd0, state}, FREE);
        beat("t5 rd100", 1'b0, 32'h100, 32'd0, 32'h12345678);
        finish_idle("t5 rd100");

        // Request dropped during wait aborts without an access.
        drive(1'b1, 1'b0, 32'h40, 32'd0);
        tick();
        check("t6 drop c1 state", {30'd0, state}, BUSY);
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        check("t6 drop c2 state", {30'd0, state}, FREE);
        tick();
        check("t6 drop c3 state", {30'd0, state}, FREE);
        check("t6 drop c3 load", load, 32'd0);

        // Zero-latency instance.
        drive0(1'b0, 1'b1, 32'h20, 32'hA5A5A5A5);
        check("t6 lat0 wr c0 state", {30'd0, state0}, FREE);
        tick();
        check("t6 lat0 wr c1 state", {30'd0, state0}, ACCESS);
        check("t6 lat0 wr c1 load", load0, 32'd0);
        drive0(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        check("t6 lat0 wr c2 state", {30'd0, state0}, FREE);
        drive0(1'b1, 1'b0, 32'h20, 32'd0);
        tick();
        check("t6 lat0 rd c1 state", {30'd0, state0}, ACCESS);
        check("t6 lat0 rd c1 load", load0, 32'hA5A5A5A5);
        drive0(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        check("t6 lat0 rd c2 state", {30'd0, state0}, FREE);
        check("t6 lat0 rd c2 load", load0, 32'd0);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
